// File: rtl/control_contador_pkg.sv
// Shared constants for the sequencing controller of the state counter.
// State encoding and default sizing live here so every file agrees on them.
package control_contador_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_DIV   = 4;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_PAUSE  = 2'b10;
    localparam logic [1:0] ST_FINISH = 2'b11;

    function automatic int cnt_bits(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// Prescaler: raises tick for one enabled cycle out of every DIV.
// The count only moves while en is high, so a pause keeps its phase.
module divisor_tick
    import control_contador_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_bits(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/control_contador.sv
// Start/pause/abort/reload sequencer for a modulo up/down counter.
// Config is captured only when leaving IDLE; later input changes are inert.
module control_contador
    import control_contador_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             up,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             wrap
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             up_cfg;
    logic             os_cfg;
    logic [WIDTH-1:0] lim_cfg;
    logic             in_idle;
    logic             in_run;
    logic             in_pause;
    logic             go;
    logic             tick;
    logic             at_end;
    logic             fin;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_run   = (state_q == ST_RUN);
    assign in_pause = (state_q == ST_PAUSE);

    // load outranks stop, which outranks start
    assign go = in_idle && !load && !stop && start;

    assign at_end = up_cfg ? (count >= lim_cfg) : (count == '0);
    assign fin    = tick && os_cfg && at_end;

    assign busy   = in_run || in_pause;
    assign paused = in_pause;
    assign done   = (state_q == ST_FINISH);

    divisor_tick #(
        .DIV (DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (go),
        .en   (in_run && !stop),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop)     state_d = ST_PAUSE;
                else if (fin) state_d = ST_FINISH;
            end
            ST_PAUSE: begin
                if (!load) begin
                    if (stop)       state_d = ST_IDLE;
                    else if (start) state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_cfg  <= 1'b0;
            os_cfg  <= 1'b0;
            lim_cfg <= '0;
        end else if (go) begin
            up_cfg  <= up;
            os_cfg  <= one_shot;
            lim_cfg <= limit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if ((in_idle || in_pause) && load) begin
                count <= load_val;
            end else if (tick && !at_end) begin
                count <= up_cfg ? count + 1'b1 : count - 1'b1;
            end else if (tick && !os_cfg) begin
                count <= up_cfg ? '0 : lim_cfg;
                wrap  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_contador.sv
// Bench for control_contador: two instances (DIV=1, DIV=4) share stimulus
// and are compared every cycle against a behavioural model, plus literals.
module tb_control_contador;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       load = 1'b0;
    logic       up = 1'b0;
    logic       one_shot = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic [2:0] limit = 3'd0;

    logic [2:0] count1, count4;
    logic       busy1, busy4;
    logic       paused1, paused4;
    logic       done1, done4;
    logic       wrap1, wrap4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    control_contador #(.WIDTH(3), .DIV(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .limit(limit), .up(up), .one_shot(one_shot),
        .count(count1), .busy(busy1), .paused(paused1), .done(done1),
        .wrap(wrap1)
    );

    control_contador #(.WIDTH(3), .DIV(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .limit(limit), .up(up), .one_shot(one_shot),
        .count(count4), .busy(busy4), .paused(paused4), .done(done4),
        .wrap(wrap4)
    );

    task automatic check(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model, one slot per instance
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_FIN} mst_t;
    mst_t m_st[2]   = '{M_IDLE, M_IDLE};
    int   m_cnt[2]  = '{0, 0};
    int   m_ph[2]   = '{0, 0};
    int   m_lim[2]  = '{0, 0};
    bit   m_up[2]   = '{0, 0};
    bit   m_os[2]   = '{0, 0};
    bit   m_wrap[2] = '{0, 0};

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic m_reset(input int i);
        m_st[i] = M_IDLE; m_cnt[i] = 0; m_ph[i] = 0;
        m_lim[i] = 0; m_up[i] = 0; m_os[i] = 0; m_wrap[i] = 0;
    endtask

    task automatic m_step(input int i);
        bit term;
        term = m_up[i] ? (m_cnt[i] >= m_lim[i]) : (m_cnt[i] == 0);
        if (term && m_os[i]) begin
            m_st[i] = M_FIN;
        end else if (term) begin
            m_cnt[i] = m_up[i] ? 0 : m_lim[i];
            m_wrap[i] = 1;
        end else begin
            m_cnt[i] = m_cnt[i] + (m_up[i] ? 1 : -1);
        end
    endtask

    task automatic m_edge(input int i);
        m_wrap[i] = 0;
        case (m_st[i])
            M_IDLE: begin
                if (load) m_cnt[i] = int'(load_val);
                else if (start && !stop) begin
                    m_up[i] = up; m_os[i] = one_shot;
                    m_lim[i] = int'(limit); m_ph[i] = 0;
                    m_st[i] = M_RUN;
                end
            end
            M_RUN: begin
                if (stop) m_st[i] = M_PAUSE;
                else begin
                    m_ph[i]++;
                    if (m_ph[i] == div_of(i)) begin
                        m_ph[i] = 0;
                        m_step(i);
                    end
                end
            end
            M_PAUSE: begin
                if (load) m_cnt[i] = int'(load_val);
                else if (stop) m_st[i] = M_IDLE;
                else if (start) m_st[i] = M_RUN;
            end
            default: m_st[i] = M_IDLE;
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) m_reset(i);
            else m_edge(i);
        end
    end

    task automatic cmp(input int i, input int c, input int b, input int p,
                       input int d, input int w);
        string t;
        t = (i == 0) ? "div1" : "div4";
        check({t, ".count"}, c, m_cnt[i]);
        check({t, ".busy"}, b, int'(m_st[i] == M_RUN || m_st[i] == M_PAUSE));
        check({t, ".paused"}, p, int'(m_st[i] == M_PAUSE));
        check({t, ".done"}, d, int'(m_st[i] == M_FIN));
        check({t, ".wrap"}, w, int'(m_wrap[i]));
    endtask

    always @(negedge clk) begin
        cmp(0, int'(count1), int'(busy1), int'(paused1), int'(done1), int'(wrap1));
        cmp(1, int'(count4), int'(busy4), int'(paused4), int'(done4), int'(wrap4));
    end

    task automatic stop_twice();
        stop = 1'b1;
        repeat (2) @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seq3[4];
        int wr3[4];
        seq3 = '{1, 0, 5, 4};
        wr3  = '{0, 0, 1, 0};

        repeat (3) @(negedge clk);
        check("rst.count", int'(count1), 0);
        check("rst.busy", int'(busy1), 0);
        check("rst.done", int'(done4), 0);
        check("rst.wrap", int'(wrap4), 0);
        rst = 1'b1;
        @(negedge clk);

        // up free-run, limit 7
        up = 1'b1; one_shot = 1'b0; limit = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1.busy", int'(busy1), 1);
        check("t1.count0", int'(count1), 0);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            check("t1.count", int'(count1), j % 8);
            check("t1.wrap", int'(wrap1), int'(j == 8));
            check("t1.busyrun", int'(busy1), 1);
        end
        stop_twice();

        // one-shot, DIV=4, limit 3
        load = 1'b1; load_val = 3'd0;
        @(negedge clk);
        load = 1'b0; up = 1'b1; one_shot = 1'b1; limit = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            if (j == 3) check("t2.c3", int'(count4), 0);
            if (j == 4) check("t2.c4", int'(count4), 1);
            if (j == 8) check("t2.c8", int'(count4), 2);
            if (j == 12) check("t2.c12", int'(count4), 3);
            if (j == 15) check("t2.busy15", int'(busy4), 1);
            if (j == 15) check("t2.done15", int'(done4), 0);
            if (j == 16) check("t2.done16", int'(done4), 1);
            if (j == 17) check("t2.done17", int'(done4), 0);
            if (j == 17) check("t2.busy17", int'(busy4), 0);
            if (j == 17) check("t2.c17", int'(count4), 3);
        end

        // down free-run from a loaded 2, limit 5
        load = 1'b1; load_val = 3'd2;
        @(negedge clk);
        load = 1'b0; up = 1'b0; one_shot = 1'b0; limit = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3.count0", int'(count1), 2);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("t3.count", int'(count1), seq3[j]);
            check("t3.wrap", int'(wrap1), wr3[j]);
        end
        stop_twice();

        // pause, reload while paused, resume
        load = 1'b1; load_val = 3'd3;
        @(negedge clk);
        load = 1'b0; up = 1'b1; one_shot = 1'b0; limit = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t4.c4", int'(count4), 4);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t4.paused", int'(paused4), 1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("t4.hold", int'(count4), 4);
            check("t4.phold", int'(paused4), 1);
        end
        load = 1'b1; load_val = 3'd6;
        @(negedge clk);
        load = 1'b0;
        check("t4.load", int'(count4), 6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4.resume", int'(paused4), 0);
        repeat (3) @(negedge clk);
        check("t4.r3", int'(count4), 6);
        @(negedge clk);
        check("t4.r4", int'(count4), 7);
        stop_twice();
        check("t4.idle", int'(busy4), 0);
        check("t4.held", int'(count4), 7);

        // simultaneous commands in IDLE, then mid-run config changes
        load = 1'b1; stop = 1'b1; start = 1'b1; load_val = 3'd1;
        @(negedge clk);
        load = 1'b0; stop = 1'b0; start = 1'b0;
        check("t5.count", int'(count1), 1);
        check("t5.busy", int'(busy1), 0);
        up = 1'b1; one_shot = 1'b0; limit = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; up = 1'b0; limit = 3'd2; one_shot = 1'b1;
        repeat (3) @(negedge clk);
        check("t5.cfg", int'(count1), 4);
        check("t5.busyrun", int'(busy1), 1);

        // asynchronous reset between edges
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("t6.count", int'(count1), 0);
        check("t6.busy", int'(busy1), 0);
        check("t6.busy4", int'(busy4), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("t6.idle1", int'(busy1), 0);
        check("t6.idle4", int'(busy4), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            start    = ($urandom_range(0, 9) < 3);
            stop     = ($urandom_range(0, 9) < 1);
            load     = ($urandom_range(0, 9) < 1);
            load_val = 3'($urandom);
            limit    = 3'($urandom);
            up       = 1'($urandom);
            one_shot = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0; stop = 1'b0; load = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_contador.md
# control_contador

Sequencing controller for the 3-bit state counter: it starts, pauses, aborts and reloads a counter of configurable width. Counting is up or down, modulo a runtime limit. A built-in prescaler slows the step rate to one step every DIV clocks. One-shot mode ends the run with a done pulse; free-run mode emits a wrap pulse on every roll-over. The block sits between front-panel/command logic and any display or timing logic that consumes `count`.

## Interface
- WIDTH, 3: counter width in bits.
- DIV, 4: clocks per count step; legal range 1..2^16-1.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (low = reset).
- start  in  1  begin or resume counting.
- stop  in  1  pause (in RUN) / abort (in PAUSE).
- load  in  1  load `load_val` into the counter.
- load_val  in  WIDTH  value for load.
- limit  in  WIDTH  modulo limit; the count range is 0..limit.
- up  in  1  1 = count up, 0 = count down.
- one_shot  in  1  1 = stop at the terminal value, 0 = free-run.
- count  out  WIDTH  current count, registered.
- busy  out  1  high in RUN or PAUSE.
- paused  out  1  high in PAUSE.
- done  out  1  one-cycle pulse in FINISH.
- wrap  out  1  one-cycle pulse on a free-run roll-over.

## Operation
- FSM states: IDLE, RUN, PAUSE, FINISH.
- Command priority within a cycle: load > stop > start.
- IDLE:
  - load: count <= load_val; the state does not change.
  - start: latch up/limit/one_shot into config registers; prescaler <= 0; go to RUN.
- RUN:
  - load and start are ignored.
  - stop: go to PAUSE; the prescaler and count hold, and no step occurs that cycle.
  - Otherwise the prescaler increments each cycle.
  - When prescaler == DIV-1, the prescaler returns to 0 and a step occurs.
- Step, up mode:
  - If count >= limit_cfg: in free-run, count <= 0 and wrap is pulsed; in one-shot, count holds and the state goes to FINISH.
  - Else count <= count+1.
- Step, down mode:
  - If count == 0: in free-run, count <= limit_cfg and wrap is pulsed; in one-shot, count holds and the state goes to FINISH.
  - Else count <= count-1.
- PAUSE:
  - load: count <= load_val.
  - stop: abort to IDLE; count retained.
  - start: resume to RUN. The prescaler is retained and the config is not re-latched.
- FINISH:
  - Lasts one cycle with done=1, then the state goes to IDLE.
  - Commands in this cycle are ignored.
- Config inputs matter only on the start edge from IDLE. Mid-run changes have no effect.
- limit_cfg == 0 is legal:
  - Up free-run holds count at 0 and pulses wrap every step.
  - Down behaves the same way.
- Reset can be asserted at any time, including mid-run. It forces every register to its reset value immediately, asynchronously.

## Timing
- Reset values: count=0, busy=0, paused=0, done=0, wrap=0, state=IDLE, prescaler=0, config registers=0.
- All outputs are registered. busy/paused are decoded from the state register.
- If start is sampled at edge k, busy=1 after edge k.
- The first count change occurs at edge k+DIV, so with DIV=1 it changes at k+1.
- Subsequent steps are every DIV edges while in RUN.
- wrap is high for exactly the cycle following the edge that rolled the count over, coincident with the new count value.
- In one-shot mode, the terminal step is sampled at edge t. The state is FINISH (done=1) during cycle t..t+1. The state is IDLE with busy=0 after edge t+1.
- Pause/resume adds no extra latency. The remaining prescaler cycles complete after resume.

## Structure
- Shared package `control_contador_pkg`:
  - State encoding: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, FINISH=2'b11.
  - Default WIDTH/DIV constants.
- Sub-module `divisor_tick`, a prescaler:
  - Parameter DIV.
  - Inputs: clk, rst, clr, en.
  - Output: tick, high combinationally when en and cnt == DIV-1.
  - Counter width: $clog2(DIV) with a minimum of 1.
- Kept in the top: the FSM (separate sequential and combinational parts), the config registers and the count datapath.

## Test plan
- Reset, then release; WIDTH=3, DIV=1, up, free-run, limit=7, start pulse → count 1,2,…,7,0 on successive cycles; wrap=1 only with count=0; busy=1 throughout.
- DIV=4, up, one-shot, limit=3, count=0, start at edge k → count=1 at k+4, 2 at k+8, 3 at k+12; done=1 in cycle k+16..k+17; busy=0 after k+17; count stays 3.
- Down, free-run, limit=5, load_val=2 loaded in IDLE, then start, DIV=1 → 1,0,5,4; wrap high with the 5.
- Mid-run stop at count=4 → paused=1, count holds 4 for 10 cycles; load 6 while paused → count=6; start → continues 7 (up, limit=7); stop twice → IDLE, count held.
- load, stop and start asserted together in IDLE → only the load takes effect; state stays IDLE. up/limit changed mid-RUN → no effect on the sequence.
- rst driven low asynchronously mid-RUN (between clock edges) → all outputs 0 immediately; after release the block stays IDLE until start.
